// File: rtl/d2b_pkg.sv
// Shared definitions for the decimal/binary converter pair: FSM encodings,
// BCD nibble constants and the double-dabble add-3 correction helpers.
package d2b_pkg;

  localparam int BCD_NIB        = 4;
  localparam int BCD_MAX_DIGITS = 8;

  localparam logic [3:0] ADD3_THRESH = 4'd5;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t CONV = 2'd1;
  localparam state_t DONE = 2'd2;

  function automatic logic [3:0] add3_nib(input logic [3:0] nib);
    if (nib >= ADD3_THRESH) begin
      add3_nib = nib + 4'd3;
    end else begin
      add3_nib = nib;
    end
  endfunction

  // Full-width correction; narrower users apply add3_nib per digit instead
  function automatic logic [BCD_NIB*BCD_MAX_DIGITS-1:0] add3_all(
    input logic [BCD_NIB*BCD_MAX_DIGITS-1:0] bcd
  );
    for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
      add3_all[i*BCD_NIB +: BCD_NIB] = add3_nib(bcd[i*BCD_NIB +: BCD_NIB]);
    end
  endfunction

endpackage

// File: rtl/submit_debounce.sv
// Submit-button filter: the level rises after CYCLES consecutive high samples
// and falls on the first low sample.
module submit_debounce
  import d2b_pkg::*;
#(
  parameter int CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt_r;

  // Count consecutive high samples; reset comes up "already pressed" so a held button never fires
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r <= CW'(CYCLES);
      dout  <= 1'b1;
    end else if (!din) begin
      cnt_r <= {CW{1'b0}};
      dout  <= 1'b0;
    end else if (cnt_r == CW'(CYCLES)) begin
      dout  <= 1'b1;
    end else begin
      cnt_r <= cnt_r + CW'(1);
      dout  <= (cnt_r == CW'(CYCLES - 1));
    end
  end

endmodule

// File: rtl/bin2bcd_display.sv
// Binary-to-BCD converter driving the LED bank, one double-dabble step per clock.
// Optional submit filter: define SUBMIT_DEBOUNCE_EN.
module bin2bcd_display
  import d2b_pkg::*;
#(
  parameter int BIN_W           = 10,
  parameter int DIGITS          = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       submit,
  input  logic [BIN_W-1:0]           binary,
  output logic [BCD_NIB*DIGITS-1:0]  LEDs,
  output logic                       busy,
  output logic                       done
);

  localparam int BCD_W = BCD_NIB * DIGITS;
  localparam int SH_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W);

  if ((((1 << BIN_W) - 1) >= 10 ** DIGITS) || (DEBOUNCE_CYCLES < 1)) begin : g_cfg_bad
    $error("bin2bcd_display: BIN_W does not fit in DIGITS, or DEBOUNCE_CYCLES < 1");
  end

  logic               submit_lvl_s;
  logic               submit_q_r;
  logic               start_s;
  state_t             state_r;
  logic [SH_W-1:0]    shreg_r;
  logic [SH_W-1:0]    sh_s;
  logic [BCD_W-1:0]   bcd_adj_s;
  logic [CNT_W-1:0]   cnt_r;

`ifdef SUBMIT_DEBOUNCE_EN
  submit_debounce #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_submit_debounce (
    .clk   (clk),
    .reset (reset),
    .din   (submit),
    .dout  (submit_lvl_s)
  );
`else
  logic submit_sync_r;

  // Single sync flop on the button; resets high like the edge history below
  always_ff @(posedge clk) begin
    if (!reset) begin
      submit_sync_r <= 1'b1;
    end else begin
      submit_sync_r <= submit;
    end
  end

  assign submit_lvl_s = submit_sync_r;
`endif

  // Edge history; resetting to 1 stops a button held through reset from starting a conversion
  always_ff @(posedge clk) begin
    if (!reset) begin
      submit_q_r <= 1'b1;
    end else begin
      submit_q_r <= submit_lvl_s;
    end
  end

  assign start_s = submit_lvl_s & ~submit_q_r;

  // Add-3 correction on every digit ahead of the shift
  always_comb begin
    bcd_adj_s = {BCD_W{1'b0}};
    for (int i = 0; i < DIGITS; i++) begin
      bcd_adj_s[i*BCD_NIB +: BCD_NIB] = add3_nib(shreg_r[BIN_W + i*BCD_NIB +: BCD_NIB]);
    end
    sh_s = {bcd_adj_s, shreg_r[BIN_W-1:0]};
  end

  // Conversion FSM: load on start, BIN_W shift steps, then one cycle to publish
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
      shreg_r <= {SH_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      LEDs    <= {BCD_W{1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_s) begin
            shreg_r <= SH_W'(binary);
            cnt_r   <= {CNT_W{1'b0}};
            busy    <= 1'b1;
            state_r <= CONV;
          end
        end
        CONV: begin
          shreg_r <= sh_s << 1;
          cnt_r   <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_W'(BIN_W - 1)) begin
            state_r <= DONE;
          end
        end
        DONE: begin
          LEDs    <= shreg_r[SH_W-1 -: BCD_W];
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_display.sv
// Randomized bench for bin2bcd_display (default build) against a decimal-arithmetic
// reference model, plus directed cases with hand-computed expectations.
module tb_bin2bcd_display;

  localparam int BIN_W  = 10;
  localparam int DIGITS = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              submit;
  logic [BIN_W-1:0]  binary;
  logic [15:0]       leds;
  logic              busy;
  logic              done;

  int checks = 0;
  int passes = 0;
  int done_cnt = 0;

  bin2bcd_display #(
    .BIN_W           (BIN_W),
    .DIGITS          (DIGITS),
    .DEBOUNCE_CYCLES (16)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .submit (submit),
    .binary (binary),
    .LEDs   (leds),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r = 16'h0;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Reference model: a press becomes a start two edges after it is first sampled; result published 11 edges later
  logic        m_sync, m_q, m_start, m_busy, m_done, model_live = 1'b0;
  logic [15:0] m_leds;
  int          ph, m_val;

  always @(posedge clk) begin
    if (!reset) begin
      m_leds = 16'h0; m_busy = 1'b0; m_done = 1'b0; ph = 0; m_sync = 1'b1; m_q = 1'b1;
    end else begin
      m_start = m_sync && !m_q;
      m_q = m_sync;
      m_sync = submit;
      m_done = 1'b0;
      if (ph == 0) begin
        if (m_start) begin
          ph = 1; m_val = int'(binary); m_busy = 1'b1;
        end
      end else begin
        ph++;
        if (ph == BIN_W + 2) begin
          m_leds = to_bcd(m_val); m_done = 1'b1; m_busy = 1'b0; ph = 0;
        end
      end
    end
    model_live = 1'b1;
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (model_live) begin
      chk("leds_vs_model", 32'(leds), 32'(m_leds));
      chk("busy_vs_model", 32'(busy), 32'(m_busy));
      chk("done_vs_model", 32'(done), 32'(m_done));
      if (done) done_cnt++;
    end
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_conv(input logic [BIN_W-1:0] v, input logic [15:0] exp, input string name);
    int n;
    @(negedge clk); binary = v; submit = 1'b1;
    @(negedge clk); submit = 1'b0;
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_latency"}, 32'(n), 32'(BIN_W + 3));
    chk({name, "_leds"}, 32'(leds), 32'(exp));
    @(negedge clk);
    chk({name, "_done_1cyc"}, 32'(done), 32'd0);
  endtask

  initial begin
    int d0;
    reset = 1'b0; submit = 1'b0; binary = 10'd0;
    cycles(3);
    chk("rst_leds", 32'(leds), 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b1;
    cycles(2);

    do_conv(10'd2,    16'h0002, "v2");
    do_conv(10'd1023, 16'h1023, "v1023");
    do_conv(10'd999,  16'h0999, "v999");
    do_conv(10'd0,    16'h0000, "v0");

    // Second press while busy must be dropped
    d0 = done_cnt;
    @(negedge clk); binary = 10'd2; submit = 1'b1;
    @(negedge clk); submit = 1'b0;
    cycles(2);
    chk("busy_at_2nd_press", 32'(busy), 32'd1);
    binary = 10'd5; submit = 1'b1;
    @(negedge clk); submit = 1'b0;
    cycles(25);
    chk("ignored_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("ignored_leds", 32'(leds), 32'h0002);

    // Reset in the middle of a conversion
    do_conv(10'd777, 16'h0777, "v777");
    d0 = done_cnt;
    @(negedge clk); binary = 10'd999; submit = 1'b1;
    @(negedge clk); submit = 1'b0;
    cycles(5);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_leds", 32'(leds), 32'h0);
    chk("abort_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    cycles(20);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    do_conv(10'd123, 16'h0123, "after_abort");

    // Button held through reset release
    d0 = done_cnt;
    @(negedge clk); submit = 1'b1; reset = 1'b0; binary = 10'd42;
    cycles(3);
    reset = 1'b1;
    cycles(20);
    chk("held_no_done", 32'(done_cnt - d0), 32'd0);
    chk("held_not_busy", 32'(busy), 32'd0);
    submit = 1'b0;
    do_conv(10'd42, 16'h0042, "after_held");

    // Random traffic checked by the model every cycle
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) submit = ~submit;
      if ($urandom_range(0, 3) == 0) binary = BIN_W'($urandom_range(0, 1023));
      reset = ($urandom_range(0, 299) != 0);
    end
    reset = 1'b1; submit = 1'b0;
    cycles(20);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
